// File: rtl/adc_pkg.sv
// Shared types and widths for the ADC0809-style capture front-end.
package adc_pkg;

  localparam int ADC_W = 8;
  localparam int CH_W  = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STRT    = 3'd1,
    WAIT_LO = 3'd2,
    WAIT_HI = 3'd3,
    READ    = 3'd4,
    DONE    = 3'd5,
    ERR     = 3'd6
  } state_t;

  function automatic logic [ADC_W-1:0] max_u8(input logic [ADC_W-1:0] a,
                                              input logic [ADC_W-1:0] b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  function automatic logic [ADC_W-1:0] min_u8(input logic [ADC_W-1:0] a,
                                              input logic [ADC_W-1:0] b);
    if (a < b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/adc_capture_minmax_window.sv
// Running min/max over WIN captured samples; publishes the final pair once per window.
module minmax_window
  import adc_pkg::*;
#(
  parameter int WIN = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADC_W-1:0] sample_i,
  input  logic             strobe_i,
  output logic [ADC_W-1:0] vmax_o,
  output logic [ADC_W-1:0] vmin_o,
  output logic             stats_valid_o
);

  localparam int CNT_W = $clog2(WIN);

  logic [ADC_W-1:0] run_max_q, run_min_q, run_max_d, run_min_d;
  logic [ADC_W-1:0] vmax_q, vmin_q;
  logic [CNT_W-1:0] cnt_q;
  logic             stats_valid_q;

  // Candidate extremes including the incoming sample; ties keep the running value.
  always_comb begin
    run_max_d = max_u8(sample_i, run_max_q);
    run_min_d = min_u8(sample_i, run_min_q);
  end

  // Window accumulation and publication.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_max_q     <= {ADC_W{1'b0}};
      run_min_q     <= {ADC_W{1'b1}};
      vmax_q        <= {ADC_W{1'b0}};
      vmin_q        <= {ADC_W{1'b1}};
      cnt_q         <= {CNT_W{1'b0}};
      stats_valid_q <= 1'b0;
    end else begin
      stats_valid_q <= 1'b0;
      if (strobe_i) begin
        if (cnt_q == CNT_W'(WIN - 1)) begin
          vmax_q        <= run_max_d;
          vmin_q        <= run_min_d;
          stats_valid_q <= 1'b1;
          run_max_q     <= {ADC_W{1'b0}};
          run_min_q     <= {ADC_W{1'b1}};
          cnt_q         <= {CNT_W{1'b0}};
        end else begin
          run_max_q <= run_max_d;
          run_min_q <= run_min_d;
          cnt_q     <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign vmax_o        = vmax_q;
  assign vmin_o        = vmin_q;
  assign stats_valid_o = stats_valid_q;

endmodule

// File: rtl/adc_capture.sv
// Conversion sequencer for an ADC0809-style converter: address/ALE/START, EOC
// handshake with timeout, OE read, sample strobe and windowed min/max statistics.
module adc_capture
  import adc_pkg::*;
#(
  parameter int START_CYC = 2,
  parameter int OE_CYC    = 2,
  parameter int TIMEOUT   = 255,
  parameter int WIN       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CH_W-1:0]  chan,
  input  logic             eoc,
  input  logic [ADC_W-1:0] adc_data,
  output logic [CH_W-1:0]  adc_addr,
  output logic             ale,
  output logic             start,
  output logic             oe,
  output logic [ADC_W-1:0] sample,
  output logic             sample_valid,
  output logic [ADC_W-1:0] vmax,
  output logic [ADC_W-1:0] vmin,
  output logic             stats_valid,
  output logic             timeout_err
);

  localparam int PH_MAX = (START_CYC > OE_CYC) ? START_CYC : OE_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);

  state_t           state_q;
  logic [PH_W-1:0]  phase_q;
  logic [TMR_W-1:0] timer_q;
  logic             eoc_meta_q, eoc_s_q;
  logic [CH_W-1:0]  adc_addr_q;
  logic             ale_q, start_q, oe_q, sample_valid_q, timeout_err_q;
  logic [ADC_W-1:0] sample_q;
  logic             cap_s;

  // The last oe clock is where data is taken, both here and in the window.
  assign cap_s = (state_q == READ) && (phase_q == PH_W'(OE_CYC - 1));

  // Two-flop synchronizer for the asynchronous end-of-conversion line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eoc_meta_q <= 1'b0;
      eoc_s_q    <= 1'b0;
    end else begin
      eoc_meta_q <= eoc;
      eoc_s_q    <= eoc_meta_q;
    end
  end

  // Conversion FSM; each EOC wait gives up after TIMEOUT clocks in that state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      phase_q        <= {PH_W{1'b0}};
      timer_q        <= {TMR_W{1'b0}};
      adc_addr_q     <= {CH_W{1'b0}};
      ale_q          <= 1'b0;
      start_q        <= 1'b0;
      oe_q           <= 1'b0;
      sample_q       <= {ADC_W{1'b0}};
      sample_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable) begin
            adc_addr_q <= chan;
            ale_q      <= 1'b1;
            start_q    <= 1'b1;
            phase_q    <= {PH_W{1'b0}};
            state_q    <= STRT;
          end
        end
        STRT: begin
          if (phase_q == PH_W'(START_CYC - 1)) begin
            ale_q   <= 1'b0;
            start_q <= 1'b0;
            timer_q <= {TMR_W{1'b0}};
            state_q <= WAIT_LO;
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
        WAIT_LO: begin
          if (!eoc_s_q) begin
            timer_q <= {TMR_W{1'b0}};
            state_q <= WAIT_HI;
          end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
            state_q <= ERR;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        WAIT_HI: begin
          if (eoc_s_q) begin
            oe_q    <= 1'b1;
            phase_q <= {PH_W{1'b0}};
            state_q <= READ;
          end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
            state_q <= ERR;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        READ: begin
          if (cap_s) begin
            oe_q           <= 1'b0;
            sample_q       <= adc_data;
            sample_valid_q <= 1'b1;
            state_q        <= DONE;
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        ERR: begin
          ale_q   <= 1'b0;
          start_q <= 1'b0;
          oe_q    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          ale_q   <= 1'b0;
          start_q <= 1'b0;
          oe_q    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
      if (!enable) begin
        timeout_err_q <= 1'b0;
      end else if (state_q == ERR) begin
        timeout_err_q <= 1'b1;
      end else begin
        timeout_err_q <= timeout_err_q;
      end
    end
  end

  minmax_window #(
    .WIN(WIN)
  ) u_window (
    .clk          (clk),
    .reset        (reset),
    .sample_i     (adc_data),
    .strobe_i     (cap_s),
    .vmax_o       (vmax),
    .vmin_o       (vmin),
    .stats_valid_o(stats_valid)
  );

  assign adc_addr     = adc_addr_q;
  assign ale          = ale_q;
  assign start        = start_q;
  assign oe           = oe_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: doc/adc_capture.md
Name: adc_capture

Overview:
- Sampling front-end for an ADC0809-style successive-approximation converter, the capture-side counterpart of the DA waveform generators in the AD interface area.
- Sequences channel address, ALE/START, EOC wait and OE read.
- Delivers each 8-bit sample with a one-cycle valid strobe.
- Tracks the min/max over a window of WIN samples, so the measured waveform can be displayed or compared against the generated one.

Parameters:
- START_CYC, 2, clocks that ale/start stay high per conversion (>=1)
- OE_CYC, 2, clocks that oe stays high before data is latched (>=1)
- TIMEOUT, 255, max clocks allowed in each EOC wait state
- WIN, 16, samples per min/max window (power of two, 2..256)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  level; conversions run back-to-back while high
- chan  in  3  requested analog channel; sampled in IDLE when a conversion launches
- eoc  in  1  converter end-of-conversion; asynchronous; double-flopped inside
- adc_data  in  8  converter data bus; valid while oe is high
- adc_addr  out  3  channel address to converter
- ale  out  1  address latch enable
- start  out  1  conversion start
- oe  out  1  converter output enable
- sample  out  8  last captured sample
- sample_valid  out  1  one-clock pulse when sample updates
- vmax  out  8  maximum of last completed window
- vmin  out  8  minimum of last completed window
- stats_valid  out  1  one-clock pulse when vmax/vmin update
- timeout_err  out  1  sticky; set on any EOC timeout, cleared by reset or enable low

Behaviour:
- Reset (reset==0, async):
  - state=IDLE; all outputs 0 except vmin=8'hFF.
  - Window counter, running max and timer are cleared; running min=8'hFF.
- eoc is used only through a 2-flop synchronizer (eoc_s). All waits below refer to eoc_s.
- FSM states:
  - IDLE: if enable, latch chan into adc_addr, go to STRT.
  - STRT: ale=start=1 for START_CYC clocks, then go to WAIT_LO.
  - WAIT_LO: wait for eoc_s==0 (conversion begun), then go to WAIT_HI. Timer counts; at TIMEOUT go to ERR.
  - WAIT_HI: wait for eoc_s==1, then go to READ. Timer restarts on entry; at TIMEOUT go to ERR.
  - READ: oe=1 for OE_CYC clocks. On the last oe clock, sample<=adc_data and go to DONE.
  - DONE: sample_valid=1 for this clock, update the window, then go to IDLE.
  - ERR: timeout_err<=1, all strobes low, go to IDLE (retry if enable still high).
- Throughput: minimum conversion = 1+START_CYC+2(sync)+OE_CYC+1 clocks plus converter time. There is no pipelining; one conversion is in flight at a time.
- Outputs ale/start/oe are registered and glitch-free; oe is never high in the same clock as start.
- enable dropping mid-conversion:
  - The current conversion completes (or times out) normally, then the FSM holds in IDLE.
  - timeout_err clears while enable==0.
- chan changes mid-conversion have no effect until the next IDLE->STRT.
- Window, in DONE:
  - run_max=max(run_max,sample); run_min=min(run_min,sample), both including the new sample; cnt+=1.
  - When cnt reaches WIN-1 (the WIN-th sample), vmax/vmin<=final values and stats_valid=1 in the same clock as sample_valid.
  - On that same clock: run_max<=0, run_min<=8'hFF, cnt<=0.
- Window across a timeout: a timeout does not advance or reset the window (the error sample is dropped).
- Equal values: a sample equal to the running max/min leaves it unchanged. Samples of 8'h00 and 8'hFF are legal extremes.
- Timer width is clog2(TIMEOUT+1); it saturates, never wraps.

Decomposition:
- Shared package adc_pkg holds:
  - state encoding constants (IDLE, STRT, WAIT_LO, WAIT_HI, READ, DONE, ERR; 3-bit);
  - ADC_W=8 and CH_W=3.
- One natural sub-module, minmax_window: holds run_max/run_min/cnt. Inputs sample + strobe; outputs vmax/vmin/stats_valid.
- The FSM, synchronizer and timer stay in adc_capture.

Test Plan:
- Converter model (EOC falls 3 clocks after start, rises 20 clocks later, data=8'h5A), chan=5, enable held high:
  - adc_addr==5 at start;
  - start high exactly 2 clocks;
  - oe 2 clocks;
  - sample==8'h5A with a single sample_valid pulse;
  - next start follows within 2 clocks.
- 16 conversions with data 10,20,...,160 -> one stats_valid on the 16th sample_valid, vmax==160, vmin==10. The next window restarts from scratch (feed 7 x16 -> vmax==vmin==7).
- EOC never rises -> ERR after 255 clocks in WAIT_HI:
  - timeout_err==1, sample_valid never pulses, window count unchanged;
  - fix the model -> captures resume while timeout_err stays 1 until enable goes low.
- enable dropped during WAIT_HI -> the conversion completes with one sample_valid, then no further start. Also change chan to 2 mid-conversion -> adc_addr stays until the next start, then shows 2.
- Assert reset low during READ -> oe, ale and start go low asynchronously; sample==0, vmin==8'hFF. After release with enable high, the first start comes 1 clock later.
- Data extremes 8'h00 and 8'hFF within one window of constant 8'h80 -> vmax==8'hFF, vmin==8'h00.
